// File: rtl/writeback_regfile.sv
// Writeback-stage consumer: picks the result, commits it to the 32-entry GPR file,
// serves two bypassed decode read ports and counts committed writes.
module writeback_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegW,
  input  logic [DATA_WIDTH-1:0]  ReadDataW,
  input  logic [DATA_WIDTH-1:0]  ALUOutW,
  input  logic [ADDR_WIDTH-1:0]  WriteRegW,
  input  logic [ADDR_WIDTH-1:0]  A1,
  input  logic [ADDR_WIDTH-1:0]  A2,
  output logic [DATA_WIDTH-1:0]  RD1,
  output logic [DATA_WIDTH-1:0]  RD2,
  output logic [DATA_WIDTH-1:0]  ResultW,
  output logic [COUNT_WIDTH-1:0] WriteCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  regs [DEPTH];
  logic [COUNT_WIDTH-1:0] count;
  logic                   we_eff;

  // r0 is never a real destination, so writes to it are neither stored nor counted
  assign we_eff  = RegWriteW && (WriteRegW != '0);
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    logic [DATA_WIDTH-1:0] value;
    if (addr == '0)
      value = '0;
    else if (wr && (wr_addr == addr))
      value = wr_data;
    else
      value = stored;
    return value;
  endfunction

  // Bypass deliberately ignores reset: decode sees the in-flight value even on a reset edge
  assign RD1 = read_port(A1, regs[A1], we_eff, WriteRegW, ResultW);
  assign RD2 = read_port(A2, regs[A2], we_eff, WriteRegW, ResultW);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (we_eff) begin
      regs[WriteRegW] <= ResultW;
    end
  end

  // Free-running modulo counter of committed writes
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (we_eff)
      count <= count + COUNT_WIDTH'(1);
  end

  assign WriteCount = count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a default instance plus a 4-bit-counter
// instance driven in parallel to observe counter wrap.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1, RD2, ResultW, WriteCount;
  logic [31:0] RD1_n, RD2_n, ResultW_n;
  logic [3:0]  WriteCount_n;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  writeback_regfile dut (
    .clock(clock), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .WriteCount(WriteCount)
  );

  writeback_regfile #(.COUNT_WIDTH(4)) dut_narrow (
    .clock(clock), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .A1(A1), .A2(A2), .RD1(RD1_n), .RD2(RD2_n), .ResultW(ResultW_n),
    .WriteCount(WriteCount_n)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0;
    ReadDataW = '0; ALUOutW = '0; WriteRegW = '0; A1 = 5'd5; A2 = '0;
    step();
    reset = 1'b0;
    #1;
    check("init_rd1_r5", RD1, 32'h0);
    check("init_count", WriteCount, 32'h0);

    // Reset after writing r5
    RegWriteW = 1'b1; WriteRegW = 5'd5; ALUOutW = 32'hDEADBEEF;
    step();
    RegWriteW = 1'b0;
    #1;
    check("r5_written", RD1, 32'hDEADBEEF);
    check("count_after_r5", WriteCount, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("r5_after_reset", RD1, 32'h0);
    check("count_after_reset", WriteCount, 32'd0);

    // Result select: memory data
    MemtoRegW = 1'b1; ReadDataW = 32'h11112222; ALUOutW = 32'h33334444;
    RegWriteW = 1'b1; WriteRegW = 5'd7; A2 = 5'd7;
    #1;
    check("result_mem", ResultW, 32'h11112222);
    check("rd2_bypass_mem", RD2, 32'h11112222);
    step();
    RegWriteW = 1'b0;
    #1;
    check("r7_mem", RD2, 32'h11112222);
    check("result_mem_no_we", ResultW, 32'h11112222);
    // Result select: ALU data
    MemtoRegW = 1'b0; RegWriteW = 1'b1;
    #1;
    check("result_alu", ResultW, 32'h33334444);
    step();
    RegWriteW = 1'b0;
    #1;
    check("r7_alu", RD2, 32'h33334444);
    check("count_after_r7", WriteCount, 32'd2);

    // Same-cycle bypass on both ports
    RegWriteW = 1'b1; WriteRegW = 5'd9; ALUOutW = 32'h12340000;
    step();
    RegWriteW = 1'b0; ALUOutW = 32'hCAFE0001; A1 = 5'd9; A2 = 5'd9;
    #1;
    check("rd1_old_r9", RD1, 32'h12340000);
    check("rd2_old_r9", RD2, 32'h12340000);
    RegWriteW = 1'b1;
    #1;
    check("rd1_bypass_r9", RD1, 32'hCAFE0001);
    check("rd2_bypass_r9", RD2, 32'hCAFE0001);
    step();
    RegWriteW = 1'b0;
    #1;
    check("rd1_new_r9", RD1, 32'hCAFE0001);
    check("count_after_r9", WriteCount, 32'd4);

    // r0 protection
    RegWriteW = 1'b1; WriteRegW = 5'd0; ALUOutW = 32'hFFFFFFFF; A1 = 5'd0;
    #1;
    check("rd1_r0_before", RD1, 32'h0);
    step();
    RegWriteW = 1'b0;
    #1;
    check("rd1_r0_after", RD1, 32'h0);
    check("count_r0_write", WriteCount, 32'd4);

    // Unknowns with RegWriteW low must not disturb state
    A1 = 5'd9; WriteRegW = 'x; ALUOutW = 'x; ReadDataW = 'x;
    step();
    #1;
    check("x_count", WriteCount, 32'd4);
    check("x_r9_intact", RD1, 32'hCAFE0001);
    ReadDataW = '0;

    // Reset wins over a concurrent write
    reset = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd3; ALUOutW = 32'h55; A1 = 5'd3;
    #1;
    check("rd1_bypass_in_reset", RD1, 32'h55);
    step();
    reset = 1'b0; RegWriteW = 1'b0;
    #1;
    check("r3_after_reset_win", RD1, 32'h0);
    check("r9_after_reset_win", RD2, 32'h0);
    check("count_after_reset_win", WriteCount, 32'd0);
    check("narrow_count_reset", WriteCount_n, 64'd0);

    // 17 effective writes with idle cycles interleaved
    for (int i = 1; i <= 17; i++) begin
      RegWriteW = 1'b1; WriteRegW = 5'(i); ALUOutW = 32'(i * 257);
      step();
      RegWriteW = 1'b0;
      step();
      check($sformatf("count_idle_%0d", i), WriteCount, 64'(i));
    end
    check("narrow_count_wrap", WriteCount_n, 64'd1);
    A1 = 5'd17; A2 = 5'd16;
    #1;
    check("r17_value", RD1, 32'h1111);
    check("r16_value", RD2, 32'h1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
